fetch: RTL and testbench



---
 rtl/fetch.sv | 24 ++
 tb/tb_fetch.sv | 54 +++++
 2 files changed

// File: rtl/fetch.sv
// fetch: program counter that steps by 4 each cycle or takes a PC-relative branch when B and Z are both set
//   Clock  : system clock, rising edge
//   Reset  : synchronous active-low reset, loads RESET_ADDR
//   B, Z   : branch decoded / ALU zero; a branch is taken only when both are 1
//   B_addr : sign-extended branch offset in words
//   addr   : registered current instruction byte address
module fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        B,
  input  logic        Z,
  input  logic [31:0] B_addr,
  output logic [31:0] addr
);
  logic [31:0] pc_q, pc_d;
  // Dropping the top two offset bits is the word-to-byte shift truncated to 32 bits.
  always_comb pc_d = pc_q + 32'd4 + ((B && Z) ? {B_addr[29:0], 2'b00} : 32'd0);
  always_ff @(posedge Clock)
    if (!Reset) pc_q <= RESET_ADDR;
    else        pc_q <= pc_d;
  assign addr = pc_q;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed-vector self-checking bench for fetch
module tb_fetch;
  logic        clk = 1'b0;
  logic        rst_n, b, z;
  logic [31:0] b_addr, addr;
  int          n_cmp = 0, n_err = 0;

  fetch dut (.Clock(clk), .Reset(rst_n), .B(b), .Z(z), .B_addr(b_addr), .addr(addr));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic bb, input logic zz, input logic [31:0] off,
                      input string tag, input logic [31:0] exp);
    rst_n = r; b = bb; z = zz; b_addr = off;
    @(posedge clk);
    #1;
    check(tag, addr, exp);
  endtask

  initial begin
    rst_n = 1'b0; b = 1'b0; z = 1'b0; b_addr = 32'h0;
    #2;
    step(1'b0, 1'b0, 1'b0, 32'h0, "reset", 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, "reset_hold", 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, "seq1", 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0, "seq2", 32'h8);
    step(1'b1, 1'b0, 1'b0, 32'h0, "seq3", 32'hC);
    step(1'b0, 1'b0, 1'b0, 32'h0, "reset_again", 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h1, "br_taken1", 32'h8);
    step(1'b1, 1'b1, 1'b1, 32'h1, "br_taken2", 32'h10);
    step(1'b1, 1'b1, 1'b0, 32'h5, "br_b_only", 32'h14);
    step(1'b1, 1'b0, 1'b1, 32'h5, "br_z_only", 32'h18);
    rst_n = 1'b0;
    #3;
    check("hold_between_edges", addr, 32'h18);
    step(1'b0, 1'b1, 1'b1, 32'h3, "reset_priority", 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h3, "reset_release", 32'h4);
    step(1'b1, 1'b1, 1'b1, 32'h6, "br_fwd", 32'h20);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, "br_back", 32'h1C);
    step(1'b1, 1'b1, 1'b1, 32'h7FFF_FFF7, "br_trunc", 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0, "wrap", 32'h0);
    step(1'b0, 1'bx, 1'bx, 32'hxxxx_xxxx, "reset_x_inputs", 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
